// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: CPU data-port decoder passing RAM through combinationally and
// bridging NCH top-of-address-space I/O channels via a req/ack handshake with timeout.
module mmio_bus_bridge #(
  parameter int NCH = 7,
  parameter int TIMEOUT = 15,
  localparam int SELW = $clog2(NCH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [31:0]       wdata,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we,
  output logic [SELW-1:0]   sel,
  output logic [NCH-1:0]    io_req,
  output logic              io_we,
  output logic [31:0]       io_wdata,
  input  logic [32*NCH-1:0] io_rdata,
  input  logic [NCH-1:0]    io_ack,
  output logic [31:0]       rdata,
  output logic              stall,
  input  logic              err_clr,
  output logic              bus_err,
  output logic [31:0]       err_addr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] off, addr_q, rd_q, ack_data;
  logic io_hit, access, ack_hit;
  assign off = ~address;
  assign io_hit = off < 32'(NCH);
  assign sel = io_hit ? SELW'(off + 32'd1) : '0;
  assign ram_we = memwrite & ~io_hit & ~reset;
  assign access = io_hit & (memwrite | memread);
  assign stall = ~reset & ((state == IDLE & access) | state == WAIT);
  assign rdata = state == DONE ? rd_q : ram_rdata;
  // io_req is one-hot on the latched channel, so it doubles as the read-data and ack select
  assign ack_hit = |(io_ack & io_req);
  always_comb begin
    ack_data = '0;
    for (int i = 0; i < NCH; i++)
      ack_data = ack_data | (io_req[i] ? io_rdata[32*i +: 32] : 32'd0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      io_req <= '0;
      io_we <= 1'b0;
      io_wdata <= '0;
      rd_q <= '0;
      cnt <= '0;
      bus_err <= 1'b0;
      err_addr <= '0;
      addr_q <= '0;
    end else begin
      if (err_clr) bus_err <= 1'b0;
      case (state)
        IDLE: if (access) begin
          io_req <= NCH'(1) << off;
          io_we <= memwrite;
          io_wdata <= wdata;
          addr_q <= address;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (ack_hit) begin
          if (!io_we) rd_q <= ack_data;
          io_req <= '0;
          state <= DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          io_req <= '0;
          rd_q <= '0;
          bus_err <= 1'b1;
          err_addr <= addr_q;
          state <= DONE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb_mmio_bus_bridge: directed stimulus with a completion scoreboard checked by a
// separate monitor that pops on every retired I/O access.
module tb_mmio_bus_bridge;
  logic clk = 1'b0;
  logic reset, memwrite, memread, err_clr;
  logic [31:0] address, wdata, ram_rdata;
  logic [32*7-1:0] io_rdata;
  logic [6:0] io_ack;
  logic ram_we, stall, io_we, bus_err;
  logic [2:0] sel;
  logic [6:0] io_req;
  logic [31:0] io_wdata, rdata, err_addr;
  logic [32*8-1:0] io_rdata8 = '0;
  logic [7:0] io_ack8 = '0;
  logic ram_we8, stall8, io_we8, bus_err8;
  logic [3:0] sel8;
  logic [7:0] io_req8;
  logic [31:0] io_wdata8, rdata8, err_addr8;
  typedef struct {logic [31:0] rdata; int len; logic err;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mmio_bus_bridge #(.NCH(7), .TIMEOUT(15)) u7 (
    .clk(clk), .reset(reset), .address(address), .memwrite(memwrite), .memread(memread),
    .wdata(wdata), .ram_rdata(ram_rdata), .ram_we(ram_we), .sel(sel), .io_req(io_req),
    .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
    .rdata(rdata), .stall(stall), .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr));

  mmio_bus_bridge #(.NCH(8), .TIMEOUT(15)) u8 (
    .clk(clk), .reset(reset), .address(address), .memwrite(memwrite), .memread(memread),
    .wdata(wdata), .ram_rdata(ram_rdata), .ram_we(ram_we8), .sel(sel8), .io_req(io_req8),
    .io_we(io_we8), .io_wdata(io_wdata8), .io_rdata(io_rdata8), .io_ack(io_ack8),
    .rdata(rdata8), .stall(stall8), .err_clr(err_clr), .bus_err(bus_err8), .err_addr(err_addr8));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic expect_done(input logic [31:0] r, input int len, input logic err);
    exp_t e;
    e.rdata = r;
    e.len = len;
    e.err = err;
    q.push_back(e);
  endtask

  task automatic do_io(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input int ack_at, input logic [6:0] ackv, input logic [6:0] noise,
                       input logic [31:0] rd, input logic [6:0] ereq, input logic [2:0] esel);
    int off;
    logic done;
    off = int'(~a);
    io_rdata = {7{32'hDEAD_BEEF}};
    io_rdata[32*off +: 32] = rd;
    address = a;
    memwrite = w;
    memread = !w;
    wdata = d;
    #1;
    chk("io_sel", 32'(sel), 32'(esel));
    chk("io_stall_first", 32'(stall), 32'd1);
    chk("io_ram_we", 32'(ram_we), 32'd0);
    done = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!stall) done = 1'b1;
      else begin
        if (i == 1) begin
          chk("io_req", 32'(io_req), 32'(ereq));
          chk("io_we", 32'(io_we), 32'(w));
          if (w) chk("io_wdata", io_wdata, d);
        end
        io_ack = (i == ack_at) ? ackv : (i < ack_at ? noise : 7'd0);
      end
    end
    if (!done) chk("io_complete_budget", 32'd0, 32'd1);
    io_ack = '0;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    memread = 1'b0;
  endtask

  initial begin
    int len;
    logic prev;
    exp_t e;
    len = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        len = 0;
        prev = 1'b0;
      end else if (stall) begin
        len++;
        prev = 1'b1;
      end else begin
        if (prev) begin
          if (q.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            chk("done_rdata", rdata, e.rdata);
            chk("stall_cycles", 32'(len), 32'(e.len));
            chk("done_bus_err", 32'(bus_err), 32'(e.err));
          end
        end
        len = 0;
        prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    address = '0;
    memwrite = 1'b0;
    memread = 1'b0;
    wdata = '0;
    ram_rdata = '0;
    io_rdata = '0;
    io_ack = '0;
    err_clr = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_io_req", 32'(io_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_io_wdata", io_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    address = 32'h0000_0040;
    wdata = 32'h1234;
    memwrite = 1'b1;
    #1;
    chk("ram_we", 32'(ram_we), 32'd1);
    chk("ram_sel", 32'(sel), 32'd0);
    chk("ram_stall", 32'(stall), 32'd0);
    chk("ram_io_req", 32'(io_req), 32'd0);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    address = 32'h0000_0100;
    memread = 1'b1;
    ram_rdata = 32'hCAFE;
    #1;
    chk("ram_rdata", rdata, 32'hCAFE);
    chk("ram_load_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    memread = 1'b0;
    expect_done(32'hA5, 3, 1'b0);
    do_io(32'hFFFF_FFFF, 1'b0, 32'h0, 2, 7'h01, 7'h00, 32'hA5, 7'h01, 3'd1);
    expect_done(32'hA5, 3, 1'b0);
    do_io(32'hFFFF_FFF9, 1'b1, 32'h55, 2, 7'h40, 7'h01, 32'h77, 7'h40, 3'd7);
    expect_done(32'h0, 16, 1'b1);
    do_io(32'hFFFF_FFFA, 1'b0, 32'h0, 0, 7'h00, 7'h00, 32'h99, 7'h20, 3'd6);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_err_addr", err_addr, 32'hFFFF_FFFA);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr_bus_err", 32'(bus_err), 32'd0);
    chk("clr_err_addr_kept", err_addr, 32'hFFFF_FFFA);
    err_clr = 1'b1;
    expect_done(32'h0, 16, 1'b1);
    do_io(32'hFFFF_FFFB, 1'b0, 32'h0, 0, 7'h00, 7'h00, 32'h99, 7'h10, 3'd5);
    err_clr = 1'b0;
    chk("set_then_clr_bus_err", 32'(bus_err), 32'd0);
    chk("to2_err_addr", err_addr, 32'hFFFF_FFFB);
    address = 32'hFFFF_FFFF;
    memread = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_io_req", 32'(io_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_io_req", 32'(io_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
    chk("mid_rst_err_addr", err_addr, 32'd0);
    memread = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    io_ack = 7'h01;
    @(posedge clk);
    #1;
    io_ack = '0;
    chk("late_ack_stall", 32'(stall), 32'd0);
    chk("late_ack_io_req", 32'(io_req), 32'd0);
    expect_done(32'h0BAD_F00D, 2, 1'b0);
    do_io(32'hFFFF_FFFE, 1'b0, 32'h0, 1, 7'h02, 7'h00, 32'h0BAD_F00D, 7'h02, 3'd2);
    address = 32'hFFFF_FFF8;
    memwrite = 1'b1;
    #1;
    chk("f8_sel_nch7", 32'(sel), 32'd0);
    chk("f8_ram_we_nch7", 32'(ram_we), 32'd1);
    chk("f8_stall_nch7", 32'(stall), 32'd0);
    chk("f8_sel_nch8", 32'(sel8), 32'd8);
    chk("f8_ram_we_nch8", 32'(ram_we8), 32'd0);
    #1;
    memwrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
